inst_fetch_ctrl: RTL and testbench



---
 rtl/inst_fetch_ctrl_pkg.sv | 24 ++
 rtl/inst_fetch_ctrl_line_buffer.sv | 62 ++++++
 rtl/inst_fetch_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared parameters, FSM encoding and counter helper for the instruction fetch controller.
// Optional hit/miss statistics are enabled by defining INST_FETCH_STATS_EN.
package inst_fetch_ctrl_pkg;

    localparam int unsigned WORD_SIZE_DEF   = 32;
    localparam int unsigned BLOCK_SIZE_DEF  = 4;
    localparam int unsigned MEM_LATENCY_DEF = 2;
    localparam int unsigned STAT_W          = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        if (value == {STAT_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_line_buffer.sv
// Single-line instruction buffer: block data, tag and valid bit, with hit compare and word select.
// A clear request always wins over a simultaneous write of the valid bit.
module inst_line_buffer
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
    parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
    localparam int unsigned OFF_W     = $clog2(BLOCK_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr_i,
    input  logic                             wr_en_i,
    input  logic                             wr_valid_i,
    input  logic [WORD_SIZE-1:0]             wr_tag_i,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0]  wr_block_i,
    input  logic [WORD_SIZE-1:0]             lk_tag_i,
    input  logic [OFF_W-1:0]                 lk_off_i,
    output logic                             hit_o,
    output logic [WORD_SIZE-1:0]             rd_word_o
);

    logic [WORD_SIZE*BLOCK_SIZE-1:0] data_q, data_d;
    logic [WORD_SIZE-1:0]            tag_q, tag_d;
    logic                            valid_q, valid_d;

    // Next-state for line contents and valid bit
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        if (wr_en_i) begin
            data_d  = wr_block_i;
            tag_d   = wr_tag_i;
            valid_d = wr_valid_i;
        end else begin
            valid_d = valid_q;
        end
        if (clr_i) begin
            valid_d = 1'b0;
        end else begin
            tag_d = tag_d;
        end
    end

    // Line storage registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    assign hit_o     = valid_q && (tag_q == lk_tag_i);
    assign rd_word_o = data_q[lk_off_i*WORD_SIZE +: WORD_SIZE];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: IDLE/FILL/RESP FSM in front of a one-line block buffer.
// Define INST_FETCH_STATS_EN to add saturating hit_count/miss_count outputs.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = WORD_SIZE_DEF,
    parameter int unsigned BLOCK_SIZE  = BLOCK_SIZE_DEF,
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    input  logic [WORD_SIZE-1:0]            req_addr,
    output logic                            req_ready,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [WORD_SIZE-1:0]            resp_inst,
    input  logic                            flush,
    output logic [WORD_SIZE-1:0]            mem_addr,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block
`ifdef INST_FETCH_STATS_EN
    ,
    output logic [STAT_W-1:0]               hit_count,
    output logic [STAT_W-1:0]               miss_count
`endif
);

    localparam int unsigned OFF_W = $clog2(BLOCK_SIZE);
    localparam int unsigned CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    fetch_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] ftag_q, ftag_d;
    logic [OFF_W-1:0]     off_q, off_d;
    logic                 flush_seen_q, flush_seen_d;
    logic [WORD_SIZE-1:0] resp_inst_q, resp_inst_d;
    logic                 ready_q, ready_d;
    logic                 rvalid_q, rvalid_d;

    logic                 accept_s, hit_s, lb_hit_s, lb_wr_s, lb_wr_valid_s;
    logic [WORD_SIZE-1:0] req_tag_s, lb_word_s, fill_word_s;
    logic [OFF_W-1:0]     req_off_s;

    assign req_tag_s   = req_addr >> OFF_W;
    assign req_off_s   = req_addr[OFF_W-1:0];
    assign accept_s    = req_valid && ready_q;
    // A flush in the accept cycle forces the miss path
    assign hit_s       = lb_hit_s && !flush;
    assign fill_word_s = mem_block[off_q*WORD_SIZE +: WORD_SIZE];

    inst_line_buffer #(
        .WORD_SIZE  (WORD_SIZE),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (flush),
        .wr_en_i    (lb_wr_s),
        .wr_valid_i (lb_wr_valid_s),
        .wr_tag_i   (ftag_q),
        .wr_block_i (mem_block),
        .lk_tag_i   (req_tag_s),
        .lk_off_i   (req_off_s),
        .hit_o      (lb_hit_s),
        .rd_word_o  (lb_word_s)
    );

    // FSM next-state, fill sequencing and response capture
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        ftag_d        = ftag_q;
        off_d         = off_q;
        flush_seen_d  = flush_seen_q;
        resp_inst_d   = resp_inst_q;
        ready_d       = ready_q;
        rvalid_d      = rvalid_q;
        lb_wr_s       = 1'b0;
        lb_wr_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    ready_d = 1'b0;
                    if (hit_s) begin
                        state_d     = ST_RESP;
                        resp_inst_d = lb_word_s;
                        rvalid_d    = 1'b1;
                    end else begin
                        state_d      = ST_FILL;
                        mem_addr_d   = {req_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                        ftag_d       = req_tag_s;
                        off_d        = req_off_s;
                        cnt_d        = '0;
                        flush_seen_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (cnt_q == CNT_LAST) begin
                    lb_wr_s       = 1'b1;
                    lb_wr_valid_s = !(flush_seen_q || flush);
                    resp_inst_d   = fill_word_s;
                    state_d       = ST_RESP;
                    rvalid_d      = 1'b1;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    flush_seen_d = flush_seen_q || flush;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b1;
                    rvalid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b1;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            ftag_q       <= '0;
            off_q        <= '0;
            flush_seen_q <= 1'b0;
            resp_inst_q  <= '0;
            ready_q      <= 1'b1;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            ftag_q       <= ftag_d;
            off_q        <= off_d;
            flush_seen_q <= flush_seen_d;
            resp_inst_q  <= resp_inst_d;
            ready_q      <= ready_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_inst  = resp_inst_q;
    assign mem_addr   = mem_addr_q;

`ifdef INST_FETCH_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters, stepped on accepted requests
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept_s && hit_s) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
        end else if (accept_s) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl; memory returns word value = word address.
// Statistics checks are included when INST_FETCH_STATS_EN is defined.
module tb_inst_fetch_ctrl;

    localparam int unsigned WS = 32;
    localparam int unsigned BS = 4;

    logic          clk = 1'b0;
    logic          rst_n, req_valid, req_ready, resp_valid, resp_ready, flush;
    logic [WS-1:0] req_addr, resp_inst, mem_addr;
    logic [WS*BS-1:0] mem_block;
`ifdef INST_FETCH_STATS_EN
    logic [31:0]   hit_count, miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory model: word i of the block holds its own word address
    always_comb begin
        mem_block = '0;
        for (int i = 0; i < BS; i++) begin
            mem_block[i*WS +: WS] = mem_addr + WS'(i);
        end
    end

    inst_fetch_ctrl #(.WORD_SIZE(WS), .BLOCK_SIZE(BS), .MEM_LATENCY(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .flush      (flush),
        .mem_addr   (mem_addr),
        .mem_block  (mem_block)
`ifdef INST_FETCH_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; flush = 1'b0;
        @(negedge clk); @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b want 0", resp_valid); end
        n_tests++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_memaddr: got %0d want 0", mem_addr); end
        n_tests++; if (resp_inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %0d want 0", resp_inst); end
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        req_valid = 1'b1; req_addr = 32'd1;
        @(negedge clk); req_valid = 1'b0;
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL cold_c1_ready: got %0b want 0", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL cold_c1_rvalid: got %0b want 0", resp_valid); end
        n_tests++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL cold_c1_memaddr: got %0d want 0", mem_addr); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL cold_c2_rvalid: got %0b want 0", resp_valid); end
        n_tests++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL cold_c2_memaddr: got %0d want 0", mem_addr); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL cold_c3_rvalid: got %0b want 1", resp_valid); end
        n_tests++; if (resp_inst !== 32'd1) begin n_fail++; $display("FAIL cold_inst: got %0d want 1", resp_inst); end
`ifdef INST_FETCH_STATS_EN
        n_tests++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL cold_misscnt: got %0d want 1", miss_count); end
`endif
        resp_ready = 1'b1;
        @(negedge clk); resp_ready = 1'b0;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL cold_idle_ready: got %0b want 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL cold_idle_rvalid: got %0b want 0", resp_valid); end
    endtask

    task automatic test_hit();
        req_valid = 1'b1; req_addr = 32'd2;
        @(negedge clk); req_valid = 1'b0;
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hit_rvalid: got %0b want 1", resp_valid); end
        n_tests++; if (resp_inst !== 32'd2) begin n_fail++; $display("FAIL hit_inst: got %0d want 2", resp_inst); end
        n_tests++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL hit_memaddr: got %0d want 0", mem_addr); end
`ifdef INST_FETCH_STATS_EN
        n_tests++; if (hit_count !== 32'd1) begin n_fail++; $display("FAIL hit_hitcnt: got %0d want 1", hit_count); end
`endif
        resp_ready = 1'b1;
        @(negedge clk); resp_ready = 1'b0;
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL hit_done_rvalid: got %0b want 0", resp_valid); end
    endtask

    task automatic test_miss_backpressure();
        req_valid = 1'b1; req_addr = 32'd35;
        @(negedge clk); req_valid = 1'b0;
        n_tests++; if (mem_addr !== 32'd32) begin n_fail++; $display("FAIL m35_c1_memaddr: got %0d want 32", mem_addr); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL m35_c1_rvalid: got %0b want 0", resp_valid); end
        @(negedge clk);
        n_tests++; if (mem_addr !== 32'd32) begin n_fail++; $display("FAIL m35_c2_memaddr: got %0d want 32", mem_addr); end
        @(negedge clk);
        n_tests++; if (resp_inst !== 32'd35) begin n_fail++; $display("FAIL m35_inst: got %0d want 35", resp_inst); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++; if (resp_valid !== 1'b1 || resp_inst !== 32'd35 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: got rv=%0b inst=%0d rdy=%0b want 1/35/0", k, resp_valid, resp_inst, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk); resp_ready = 1'b0;
        n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got rdy=%0b rv=%0b want 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_flush_fill();
        req_valid = 1'b1; req_addr = 32'd4;
        @(negedge clk); req_valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1 || resp_inst !== 32'd4) begin
            n_fail++; $display("FAIL ff_resp: got rv=%0b inst=%0d want 1/4", resp_valid, resp_inst);
        end
        resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd5;
        @(negedge clk); req_valid = 1'b0;
        n_tests++; if (resp_valid !== 1'b0 || mem_addr !== 32'd4) begin
            n_fail++; $display("FAIL ff_remiss: got rv=%0b memaddr=%0d want 0/4", resp_valid, mem_addr);
        end
        @(negedge clk); @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1 || resp_inst !== 32'd5) begin
            n_fail++; $display("FAIL ff_inst5: got rv=%0b inst=%0d want 1/5", resp_valid, resp_inst);
        end
        resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    endtask

    task automatic test_flush_accept();
        req_valid = 1'b1; req_addr = 32'd6; flush = 1'b1;
        @(negedge clk); req_valid = 1'b0; flush = 1'b0;
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL fa_miss: got rv=%0b want 0", resp_valid); end
        @(negedge clk); @(negedge clk);
        n_tests++; if (resp_inst !== 32'd6) begin n_fail++; $display("FAIL fa_inst: got %0d want 6", resp_inst); end
        resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd7;
        @(negedge clk); req_valid = 1'b0;
        n_tests++; if (resp_valid !== 1'b1 || resp_inst !== 32'd7) begin
            n_fail++; $display("FAIL fa_refill_hit: got rv=%0b inst=%0d want 1/7", resp_valid, resp_inst);
        end
`ifdef INST_FETCH_STATS_EN
        n_tests++; if (hit_count !== 32'd2 || miss_count !== 32'd5) begin
            n_fail++; $display("FAIL fa_stats: got hit=%0d miss=%0d want 2/5", hit_count, miss_count);
        end
`endif
        resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    endtask

    task automatic test_flush_idle();
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        req_valid = 1'b1; req_addr = 32'd7;
        @(negedge clk); req_valid = 1'b0;
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL fi_miss: got rv=%0b want 0", resp_valid); end
        @(negedge clk); @(negedge clk);
        n_tests++; if (resp_inst !== 32'd7) begin n_fail++; $display("FAIL fi_inst: got %0d want 7", resp_inst); end
        resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        req_valid = 1'b1; req_addr = 32'd40;
        @(negedge clk); req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        n_tests++; if (req_ready !== 1'b1 || mem_addr !== 32'd0) begin
            n_fail++; $display("FAIL ra_state: got rdy=%0b memaddr=%0d want 1/0", req_ready, mem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL ra_noresp%0d: got %0b want 0", k, resp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_miss_backpressure();
        test_flush_fill();
        test_flush_accept();
        test_flush_idle();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
